// File: rtl/spi_trace_pkg.sv
// spi_trace_pkg: command codes, header layout and frame phase shared by the SPI trace link.
package spi_trace_pkg;
   localparam logic [7:0] RESYNC_CMD = 8'hA5;
   localparam logic [7:0] WIDTH_CMD = 8'hA0;
   localparam logic [7:0] WIDTH_CMD_MASK = 8'hF1;
   localparam int HDR_REAL_N = 7;
   localparam int HDR_WIDTH_LSB = 1;
   localparam int HDR_SYNC = 0;
   typedef enum logic {PH_HDR, PH_PAY} phase_t;
   function automatic logic [7:0] make_hdr(input logic is_real, input logic [1:0] width, input logic sync);
      make_hdr = '0;
      make_hdr[HDR_REAL_N] = ~is_real;
      make_hdr[HDR_WIDTH_LSB +: 2] = width;
      make_hdr[HDR_SYNC] = sync;
   endfunction
endpackage

// File: rtl/spi_word_fifo.sv
// spi_word_fifo: synchronous show-ahead word FIFO; accepts a push at full when a pop frees a slot.
module spi_word_fifo #(
   parameter int W = 16,
   parameter int DEPTH = 16
) (
   input logic clk,
   input logic rst,
   input logic push,
   input logic [W-1:0] din,
   input logic pop,
   output logic [W-1:0] dout,
   output logic ready,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_push;
   assign ready = count != (AW+1)'(DEPTH) || pop;
   assign do_push = push && ready;
   assign dout = mem[rp];
   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         wp <= do_push ? wp + AW'(1) : wp;
         rp <= pop ? rp + AW'(1) : rp;
         count <= count + (AW+1)'(do_push) - (AW+1)'(pop);
      end
   end
endmodule

// File: rtl/spi_trace_link.sv
// spi_trace_link: SPI slave that streams framed trace words from a FIFO to the host
// and decodes width/resync commands arriving on MOSI.
module spi_trace_link import spi_trace_pkg::*; #(
   parameter int WORD_W = 16,
   parameter int WORDS_PER_FRAME = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int STRETCH_W = 16
) (
   input logic clk,
   input logic rst,
   input logic spi_sclk,
   input logic spi_mosi,
   output logic spi_miso,
   input logic [WORD_W-1:0] word_in,
   input logic word_valid,
   output logic word_ready,
   input logic sync_in,
   output logic [2:0] width_enc,
   output logic frame_reset,
   output logic [7:0] rx_byte,
   output logic rx_byte_valid,
   output logic active
);
   localparam int BPW = WORD_W / 8;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   logic [2:0] sclk_s, rx_cnt, tx_cnt;
   logic [1:0] mosi_s, width, byte_idx;
   logic [7:0] rx_sr, rx_nxt, tx_sr, tx_byte;
   logic [3:0] word_idx;
   logic [WORD_W-1:0] cur_word, load_word, fifo_dout;
   logic [CW-1:0] fifo_cnt;
   logic [STRETCH_W-1:0] stretch;
   logic rise, fall, abort, pop, fifo_ready, hdr_real, is_real, last_byte;
   phase_t phase;
   assign rise = sclk_s[1] & ~sclk_s[2];
   assign fall = ~sclk_s[1] & sclk_s[2];
   assign rx_nxt = {rx_sr[6:0], mosi_s[1]};
   assign abort = fall && (rx_nxt == RESYNC_CMD || (rx_cnt == 3'd7 && (rx_nxt & WIDTH_CMD_MASK) == WIDTH_CMD));
   assign hdr_real = fifo_cnt >= CW'(WORDS_PER_FRAME);
   assign load_word = byte_idx == 2'd0 ? (is_real ? fifo_dout : '0) : cur_word;
   assign tx_byte = phase == PH_HDR ? make_hdr(hdr_real, width, sync_in) : load_word[7:0];
   assign pop = rise && tx_cnt == 3'd0 && phase == PH_PAY && byte_idx == 2'd0 && is_real;
   assign word_ready = rst && fifo_ready;
   assign width_enc = {1'b0, width} + 3'd1;
   assign active = |stretch;
   spi_word_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(word_valid && word_ready), .din(word_in),
      .pop(pop), .dout(fifo_dout), .ready(fifo_ready), .count(fifo_cnt)
   );
   // Resync matches on any bit alignment; normal bytes complete every 8th bit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sclk_s <= '0;
         mosi_s <= '0;
         rx_sr <= '0;
         rx_cnt <= '0;
         rx_byte <= '0;
         rx_byte_valid <= 1'b0;
         frame_reset <= 1'b0;
         width <= 2'd3;
      end else begin
         sclk_s <= {sclk_s[1:0], spi_sclk};
         mosi_s <= {mosi_s[0], spi_mosi};
         frame_reset <= fall && rx_nxt == RESYNC_CMD;
         rx_byte_valid <= fall && rx_nxt != RESYNC_CMD && rx_cnt == 3'd7 && rx_nxt != 8'h00;
         if (fall) begin
            rx_sr <= rx_nxt == RESYNC_CMD ? 8'h00 : rx_nxt;
            rx_cnt <= rx_nxt == RESYNC_CMD ? 3'd0 : rx_cnt + 3'd1;
            if (rx_nxt != RESYNC_CMD && rx_cnt == 3'd7 && rx_nxt != 8'h00) begin
               rx_byte <= rx_nxt;
               width <= (rx_nxt & WIDTH_CMD_MASK) == WIDTH_CMD ? rx_nxt[3:2] : width;
            end
         end
      end
   end
   // A new byte loads when tx_cnt wraps to 0; is_real spans header load to the frame's last bit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         phase <= PH_HDR;
         tx_cnt <= '0;
         tx_sr <= '0;
         spi_miso <= 1'b0;
         is_real <= 1'b0;
         last_byte <= 1'b0;
         byte_idx <= '0;
         word_idx <= '0;
         cur_word <= '0;
      end else if (abort) begin
         phase <= PH_HDR;
         tx_cnt <= '0;
         is_real <= 1'b0;
         last_byte <= 1'b0;
         byte_idx <= '0;
      end else if (rise) begin
         spi_miso <= tx_cnt == 3'd0 ? tx_byte[7] : tx_sr[7];
         tx_sr <= tx_cnt == 3'd0 ? {tx_byte[6:0], 1'b0} : {tx_sr[6:0], 1'b0};
         tx_cnt <= tx_cnt + 3'd1;
         if (tx_cnt == 3'd0 && phase == PH_HDR) begin
            is_real <= hdr_real;
            phase <= PH_PAY;
            byte_idx <= '0;
            word_idx <= '0;
         end else if (tx_cnt == 3'd0) begin
            cur_word <= load_word >> 8;
            byte_idx <= byte_idx == 2'(BPW - 1) ? 2'd0 : byte_idx + 2'd1;
            if (byte_idx == 2'(BPW - 1)) begin
               word_idx <= word_idx + 4'd1;
               phase <= word_idx == 4'(WORDS_PER_FRAME - 1) ? PH_HDR : PH_PAY;
               last_byte <= word_idx == 4'(WORDS_PER_FRAME - 1);
            end
         end else if (tx_cnt == 3'd7 && last_byte) begin
            is_real <= 1'b0;
            last_byte <= 1'b0;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) stretch <= '0;
      else stretch <= is_real ? '1 : (|stretch ? stretch - STRETCH_W'(1) : '0);
   end
endmodule

// File: tb/tb_spi_trace_link.sv
// tb_spi_trace_link: drives SPI bytes and FIFO pushes, checks every MISO byte against a
// byte/queue-level frame model.
module tb_spi_trace_link;
   localparam int WORD_W = 16;
   localparam int WPF = 8;
   localparam int DEPTH = 16;
   logic clk = 1'b0, rst = 1'b0, spi_sclk = 1'b0, spi_mosi = 1'b0, word_valid = 1'b0, sync_in = 1'b0;
   logic spi_miso, word_ready, frame_reset, rx_byte_valid, active;
   logic [WORD_W-1:0] word_in = '0;
   logic [2:0] width_enc;
   logic [7:0] rx_byte;
   int total = 0, bad = 0, fr_cnt = 0, rv_cnt = 0;
   logic [WORD_W-1:0] q[$];
   logic [7:0] pend[$];
   int slots = 0;
   bit m_real = 1'b0;
   logic [1:0] m_width = 2'd3;
   always #5 clk = ~clk;
   spi_trace_link #(.WORD_W(WORD_W), .WORDS_PER_FRAME(WPF), .FIFO_DEPTH(DEPTH), .STRETCH_W(16)) dut (
      .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
      .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready), .sync_in(sync_in),
      .width_enc(width_enc), .frame_reset(frame_reset), .rx_byte(rx_byte),
      .rx_byte_valid(rx_byte_valid), .active(active)
   );
   always @(negedge clk) begin
      if (frame_reset) fr_cnt++;
      if (rx_byte_valid) rv_cnt++;
   end
   function automatic logic [7:0] model_next();
      logic [WORD_W-1:0] w;
      if (pend.size() == 0) begin
         if (slots == 0) begin
            m_real = q.size() >= WPF;
            slots = WPF;
            return {~m_real, 4'b0000, m_width, sync_in};
         end
         slots--;
         w = m_real ? q.pop_front() : '0;
         for (int b = 0; b < WORD_W / 8; b++) pend.push_back(w[8*b +: 8]);
      end
      return pend.pop_front();
   endfunction
   function automatic void model_cmd(input logic [7:0] m);
      if (m == 8'hA5 || (m & 8'hF1) == 8'hA0) begin
         pend.delete();
         slots = 0;
      end
      if ((m & 8'hF1) == 8'hA0) m_width = m[3:2];
   endfunction
   function automatic void model_reset();
      q.delete();
      pend.delete();
      slots = 0;
      m_width = 2'd3;
   endfunction
   task automatic xfer(input logic [7:0] m, output logic [7:0] got, output logic [7:0] e);
      e = model_next();
      for (int i = 7; i >= 0; i--) begin
         spi_sclk = 1'b1;
         spi_mosi = m[i];
         #45 got[i] = spi_miso;
         #5 spi_sclk = 1'b0;
         #50;
      end
      model_cmd(m);
   endtask
   task automatic push_word(input logic [WORD_W-1:0] w, output logic acc);
      word_in = w;
      word_valid = 1'b1;
      #1 acc = word_ready;
      @(posedge clk);
      #2 word_valid = 1'b0;
   endtask
   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      total += 7;
      if (spi_miso !== 1'b0) begin bad++; $display("FAIL reset miso: got %b want 0", spi_miso); end
      if (word_ready !== 1'b0) begin bad++; $display("FAIL reset word_ready: got %b want 0", word_ready); end
      if (width_enc !== 3'd4) begin bad++; $display("FAIL reset width_enc: got %0d want 4", width_enc); end
      if (frame_reset !== 1'b0) begin bad++; $display("FAIL reset frame_reset: got %b want 0", frame_reset); end
      if (rx_byte !== 8'h00) begin bad++; $display("FAIL reset rx_byte: got %h want 00", rx_byte); end
      if (rx_byte_valid !== 1'b0) begin bad++; $display("FAIL reset rx_byte_valid: got %b want 0", rx_byte_valid); end
      if (active !== 1'b0) begin bad++; $display("FAIL reset active: got %b want 0", active); end
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #2;
   endtask
   task automatic test_idle_frame();
      logic [7:0] g, e;
      int rv0;
      rv0 = rv_cnt;
      for (int k = 0; k < 20; k++) begin
         xfer(8'h00, g, e);
         total++;
         if (g !== e) begin bad++; $display("FAIL idle byte %0d: got %h want %h", k, g, e); end
         if (k == 0) begin
            total++;
            if (g !== 8'h86) begin bad++; $display("FAIL idle header: got %h want 86", g); end
         end
      end
      total += 2;
      if (active !== 1'b0) begin bad++; $display("FAIL idle active: got %b want 0", active); end
      if (rv_cnt - rv0 !== 0) begin bad++; $display("FAIL idle rx_valid count: got %0d want 0", rv_cnt - rv0); end
   endtask
   task automatic test_real_frame();
      logic [7:0] g, e, w;
      logic acc, er;
      int fr0;
      sync_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         er = q.size() < DEPTH;
         push_word(16'(16'h0100 + i), acc);
         total++;
         if (acc !== er) begin bad++; $display("FAIL real push %0d ready: got %b want %b", i, acc, er); end
         if (er) q.push_back(16'(16'h0100 + i));
      end
      fr0 = fr_cnt;
      xfer(8'hA5, g, e);
      total += 2;
      if (g !== e) begin bad++; $display("FAIL real resync byte: got %h want %h", g, e); end
      if (fr_cnt - fr0 !== 1) begin bad++; $display("FAIL real frame_reset count: got %0d want 1", fr_cnt - fr0); end
      for (int k = 0; k < 17; k++) begin
         xfer(8'h00, g, e);
         total++;
         if (g !== e) begin bad++; $display("FAIL real byte %0d: got %h want %h", k, g, e); end
         if (k > 0) begin
            w = (k - 1) % 2 == 0 ? 8'((k - 1) / 2) : 8'h01;
            total++;
            if (g !== w) begin bad++; $display("FAIL real wire byte %0d: got %h want %h", k, g, w); end
         end
      end
      total += 2;
      if (active !== 1'b1) begin bad++; $display("FAIL real active: got %b want 1", active); end
      if (q.size() !== 0) begin bad++; $display("FAIL real model fifo left: got %0d want 0", q.size()); end
   endtask
   task automatic test_width_cmd();
      logic [7:0] g, e;
      int rv0;
      rv0 = rv_cnt;
      xfer(8'hA4, g, e);
      total += 4;
      if (g !== e) begin bad++; $display("FAIL width cmd byte: got %h want %h", g, e); end
      if (rv_cnt - rv0 !== 1) begin bad++; $display("FAIL width rx_valid count: got %0d want 1", rv_cnt - rv0); end
      if (rx_byte !== 8'hA4) begin bad++; $display("FAIL width rx_byte: got %h want a4", rx_byte); end
      if (width_enc !== 3'd2) begin bad++; $display("FAIL width width_enc: got %0d want 2", width_enc); end
      for (int k = 0; k < 3; k++) begin
         xfer(8'h00, g, e);
         total++;
         if (g !== e) begin bad++; $display("FAIL width byte %0d: got %h want %h", k, g, e); end
         if (k == 0) begin
            total++;
            if (g[2:1] !== 2'b01 || g[7] !== 1'b1) begin bad++; $display("FAIL width header: got %h want width 1, no data", g); end
         end
      end
   endtask
   task automatic test_resync();
      logic [7:0] g, e;
      logic [WORD_W-1:0] w;
      logic acc, er;
      int fr0;
      for (int i = 0; i < 12; i++) begin
         w = WORD_W'($urandom);
         er = q.size() < DEPTH;
         push_word(w, acc);
         total++;
         if (acc !== er) begin bad++; $display("FAIL resync push %0d ready: got %b want %b", i, acc, er); end
         if (er) q.push_back(w);
      end
      xfer(8'hA5, g, e);
      total++;
      if (g !== e) begin bad++; $display("FAIL resync align byte: got %h want %h", g, e); end
      for (int k = 0; k < 7; k++) begin
         xfer(8'h00, g, e);
         total++;
         if (g !== e) begin bad++; $display("FAIL resync pre byte %0d: got %h want %h", k, g, e); end
      end
      fr0 = fr_cnt;
      xfer(8'hA5, g, e);
      total += 2;
      if (g !== e) begin bad++; $display("FAIL resync word3 byte: got %h want %h", g, e); end
      if (fr_cnt - fr0 !== 1) begin bad++; $display("FAIL resync frame_reset count: got %0d want 1", fr_cnt - fr0); end
      for (int k = 0; k < 17; k++) begin
         xfer(8'h00, g, e);
         total++;
         if (g !== e) begin bad++; $display("FAIL resync post byte %0d: got %h want %h", k, g, e); end
      end
   endtask
   task automatic test_fifo_full();
      logic [7:0] g, e;
      logic [WORD_W-1:0] w, held;
      logic acc, er;
      for (int i = 0; i < 17; i++) begin
         w = WORD_W'($urandom);
         er = q.size() < DEPTH;
         push_word(w, acc);
         total++;
         if (acc !== er) begin bad++; $display("FAIL full push %0d ready: got %b want %b", i, acc, er); end
         if (er) q.push_back(w);
         held = w;
      end
      for (int k = 0; k < 17; k++) begin
         xfer(8'h00, g, e);
         total++;
         if (g !== e) begin bad++; $display("FAIL full byte %0d: got %h want %h", k, g, e); end
      end
      push_word(held, acc);
      total++;
      if (acc !== 1'b1) begin bad++; $display("FAIL full held push ready: got %b want 1", acc); end
      q.push_back(held);
   endtask
   task automatic test_reset_mid_frame();
      logic [7:0] g, e;
      for (int k = 0; k < 4; k++) begin
         xfer(8'h00, g, e);
         total++;
         if (g !== e) begin bad++; $display("FAIL mid byte %0d: got %h want %h", k, g, e); end
      end
      rst = 1'b0;
      @(posedge clk);
      #2;
      total += 7;
      if (spi_miso !== 1'b0) begin bad++; $display("FAIL mid reset miso: got %b want 0", spi_miso); end
      if (word_ready !== 1'b0) begin bad++; $display("FAIL mid reset word_ready: got %b want 0", word_ready); end
      if (width_enc !== 3'd4) begin bad++; $display("FAIL mid reset width_enc: got %0d want 4", width_enc); end
      if (frame_reset !== 1'b0) begin bad++; $display("FAIL mid reset frame_reset: got %b want 0", frame_reset); end
      if (rx_byte !== 8'h00) begin bad++; $display("FAIL mid reset rx_byte: got %h want 00", rx_byte); end
      if (rx_byte_valid !== 1'b0) begin bad++; $display("FAIL mid reset rx_byte_valid: got %b want 0", rx_byte_valid); end
      if (active !== 1'b0) begin bad++; $display("FAIL mid reset active: got %b want 0", active); end
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
         xfer(8'h00, g, e);
         total++;
         if (g !== e) begin bad++; $display("FAIL mid post byte %0d: got %h want %h", k, g, e); end
         if (k == 0) begin
            total++;
            if (g[7] !== 1'b1 || g[2:1] !== 2'b11) begin bad++; $display("FAIL mid post header: got %h want width 3, no data", g); end
         end
      end
   endtask
   task automatic test_random();
      logic [7:0] g, e, m;
      logic [WORD_W-1:0] w;
      logic [1:0] wv;
      logic acc, er;
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < int'($urandom_range(0, 10)); i++) begin
            w = WORD_W'($urandom);
            er = q.size() < DEPTH;
            push_word(w, acc);
            total++;
            if (acc !== er) begin bad++; $display("FAIL rand push ready: got %b want %b", acc, er); end
            if (er) q.push_back(w);
         end
         sync_in = 1'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            wv = 2'($urandom_range(0, 3));
            m = {4'hA, wv, 2'b00};
            xfer(m, g, e);
            total += 2;
            if (g !== e) begin bad++; $display("FAIL rand width byte: got %h want %h", g, e); end
            if (width_enc !== {1'b0, wv} + 3'd1) begin bad++; $display("FAIL rand width_enc: got %0d want %0d", width_enc, wv + 1); end
         end
         xfer(8'hA5, g, e);
         total++;
         if (g !== e) begin bad++; $display("FAIL rand resync byte: got %h want %h", g, e); end
         for (int k = 0; k < 17; k++) begin
            xfer(8'h00, g, e);
            total++;
            if (g !== e) begin bad++; $display("FAIL rand round %0d byte %0d: got %h want %h", r, k, g, e); end
         end
      end
   endtask
   initial begin
      @(posedge clk);
      #2;
      test_reset();
      test_idle_frame();
      test_real_frame();
      test_width_cmd();
      test_resync();
      test_fifo_full();
      test_reset_mid_frame();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
